// File: rtl/alu_issue_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_queue                                                          |
// | Age-ordered collapsing ALU issue queue with scoreboard/wakeup tracking.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_issue_queue #(
  parameter int DW    = 160,
  parameter int DP    = 8,
  parameter int RNBIT = 2,
  parameter int WB_CH = 2,
  localparam int IW   = 5 + RNBIT,
  localparam int NREG = 32 << RNBIT,
  localparam int OW   = $clog2(DP + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                dispat_vaild,
  output logic                dispat_ready,
  input  logic [DW-1:0]       dispat_info,
  input  logic [IW-1:0]       dispat_rs1,
  input  logic [IW-1:0]       dispat_rs2,
  input  logic                dispat_rs1_use,
  input  logic                dispat_rs2_use,
  input  logic [NREG-1:0]     wbBuf_qout,
  input  logic [WB_CH-1:0]    wb_vaild,
  input  logic [WB_CH*IW-1:0] wb_index,
  input  logic                exe_ready,
  output logic                exe_vaild,
  output logic [DW-1:0]       exe_info,
  output logic [IW-1:0]       exe_rs1,
  output logic [IW-1:0]       exe_rs2,
  input  logic                flush,
  output logic [OW-1:0]       occupancy
);

  logic [DP-1:0] valid_q, valid_d;
  logic [DP-1:0] rdy1_q, rdy1_d;
  logic [DP-1:0] rdy2_q, rdy2_d;
  logic [DW-1:0] info_q [DP];
  logic [DW-1:0] info_d [DP];
  logic [IW-1:0] rs1_q  [DP];
  logic [IW-1:0] rs1_d  [DP];
  logic [IW-1:0] rs2_q  [DP];
  logic [IW-1:0] rs2_d  [DP];
  logic [OW-1:0] occ_q, occ_d;

  logic [DP-1:0] cand, older, onehot, at_or_above;
  logic [DP-1:0] woke1, woke2;
  logic          push_w, pop_w, acc;
  logic [OW-1:0] push_slot;

  function automatic logic wb_hit(input logic [IW-1:0]       idx,
                                  input logic [WB_CH-1:0]    vld,
                                  input logic [WB_CH*IW-1:0] widx);
    logic h;
    h = 1'b0;
    for (int c = 0; c < WB_CH; c++) begin
      if (vld[c] && (widx[IW*c +: IW] == idx)) h = 1'b1;
    end
    return h;
  endfunction

  assign dispat_ready = (occ_q != OW'(DP));
  assign occupancy    = occ_q;
  assign push_w       = dispat_vaild & dispat_ready;
  assign pop_w        = exe_vaild & exe_ready;
  assign push_slot    = occ_q - OW'(pop_w);

  // Oldest-first pick: older[i] marks a ready entry somewhere below slot i.
  always_comb begin
    cand        = valid_q & rdy1_q & rdy2_q;
    older       = '0;
    acc         = 1'b0;
    for (int i = 0; i < DP; i++) begin
      older[i] = acc;
      acc      = acc | cand[i];
    end
    onehot      = cand & ~older;
    at_or_above = older | cand;
    exe_vaild   = |cand;
    exe_info    = '0;
    exe_rs1     = '0;
    exe_rs2     = '0;
    for (int i = 0; i < DP; i++) begin
      exe_info = exe_info | ({DW{onehot[i]}} & info_q[i]);
      exe_rs1  = exe_rs1  | ({IW{onehot[i]}} & rs1_q[i]);
      exe_rs2  = exe_rs2  | ({IW{onehot[i]}} & rs2_q[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < DP; i++) begin
      woke1[i] = rdy1_q[i] | wb_hit(rs1_q[i], wb_vaild, wb_index);
      woke2[i] = rdy2_q[i] | wb_hit(rs2_q[i], wb_vaild, wb_index);
    end
    valid_d = valid_q;
    rdy1_d  = woke1;
    rdy2_d  = woke2;
    info_d  = info_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    occ_d   = occ_q + OW'(push_w) - OW'(pop_w);

    // Collapse: the issued slot and everything above it move down by one.
    if (pop_w) begin
      for (int i = 0; i < DP - 1; i++) begin
        if (at_or_above[i]) begin
          valid_d[i] = valid_q[i+1];
          rdy1_d[i]  = woke1[i+1];
          rdy2_d[i]  = woke2[i+1];
          info_d[i]  = info_q[i+1];
          rs1_d[i]   = rs1_q[i+1];
          rs2_d[i]   = rs2_q[i+1];
        end
      end
      valid_d[DP-1] = 1'b0;
    end

    if (push_w) begin
      for (int i = 0; i < DP; i++) begin
        if (push_slot == OW'(i)) begin
          valid_d[i] = 1'b1;
          info_d[i]  = dispat_info;
          rs1_d[i]   = dispat_rs1;
          rs2_d[i]   = dispat_rs2;
          rdy1_d[i]  = ~dispat_rs1_use | wbBuf_qout[dispat_rs1]
                     | wb_hit(dispat_rs1, wb_vaild, wb_index);
          rdy2_d[i]  = ~dispat_rs2_use | wbBuf_qout[dispat_rs2]
                     | wb_hit(dispat_rs2, wb_vaild, wb_index);
        end
      end
    end

    if (flush) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      occ_q   <= '0;
      for (int i = 0; i < DP; i++) begin
        info_q[i] <= '0;
        rs1_q[i]  <= '0;
        rs2_q[i]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      occ_q   <= occ_d;
      for (int i = 0; i < DP; i++) begin
        info_q[i] <= info_d[i];
        rs1_q[i]  <= rs1_d[i];
        rs2_q[i]  <= rs2_d[i];
      end
    end
  end

endmodule
`default_nettype wire
